// File: rtl/hack_pkg.sv
// Shared Hack gate-library types.
// Word width and word type used by memory blocks.
package hack_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/register_n.sv
// One WIDTH-bit word with load and synchronous clear.
// Async active-low reset; clear beats load.
module register_n #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // next word: clear, else load, else hold
   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else if (load) begin
         data_d = in;
      end
   end

   // word storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign out = data_q;

endmodule

// File: rtl/ram_n.sv
// DEPTH x WIDTH register memory, one write port,
// combinational read with per-word written flags.
module ram_n
   import hack_pkg::*;
#(
   parameter  int WIDTH  = WORD_W,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              written
);

   logic [DEPTH-1:0] ld;
   logic [DEPTH-1:0] flag_q;
   logic [DEPTH-1:0] flag_d;
   logic [WIDTH-1:0] word_q [DEPTH];

   // one-hot load; out-of-range addresses select nothing
   always_comb begin
      ld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ld[i] = load && (address == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      register_n #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (clear),
         .load  (ld[g]),
         .in    (in),
         .out   (word_q[g])
      );
   end

   // written flags: set on load, wiped by clear
   always_comb begin
      flag_d = flag_q | ld;
      if (clear) begin
         flag_d = '0;
      end
   end

   // written flag storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= '0;
      end else begin
         flag_q <= flag_d;
      end
   end

   // read mux; out-of-range reads return zero
   always_comb begin
      out     = '0;
      written = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) begin
            out     = word_q[i];
            written = flag_q[i];
         end
      end
   end

endmodule

// File: tb/tb_ram_n.sv
// Directed bench for ram_n: DEPTH=8 and DEPTH=5 instances.
// Expected values are hand-computed constants.
module tb_ram_n;
   import hack_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        clear;

   word_t       in8;
   logic        load8;
   logic [2:0]  addr8;
   word_t       out8;
   logic        wr8;

   word_t       in5;
   logic        load5;
   logic [2:0]  addr5;
   word_t       out5;
   logic        wr5;

   int n_chk;
   int n_fail;

   ram_n #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in8),
      .load    (load8),
      .address (addr8),
      .clear   (clear),
      .out     (out8),
      .written (wr8)
   );

   ram_n #(.WIDTH(16), .DEPTH(5)) dut5 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in5),
      .load    (load5),
      .address (addr5),
      .clear   (clear),
      .out     (out5),
      .written (wr5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr8_at(input logic [2:0] a, input word_t d);
      @(negedge clk);
      load8 = 1'b1;
      addr8 = a;
      in8   = d;
      @(posedge clk);
      #1;
      load8 = 1'b0;
   endtask

   task automatic wr5_at(input logic [2:0] a, input word_t d);
      @(negedge clk);
      load5 = 1'b1;
      addr5 = a;
      in5   = d;
      @(posedge clk);
      #1;
      load5 = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      clear  = 1'b0;
      in8    = '0;
      load8  = 1'b0;
      addr8  = '0;
      in5    = '0;
      load5  = 1'b0;
      addr5  = '0;

      // 1: reset state, no edge needed
      #1;
      for (int i = 0; i < 8; i++) begin
         addr8 = 3'(i);
         #0.1;
         chk($sformatf("rst_out%0d", i), 32'(out8), 32'h0);
         chk($sformatf("rst_wr%0d", i), 32'(wr8), 32'h0);
      end

      // write during reset must be lost
      @(negedge clk);
      load8 = 1'b1;
      addr8 = 3'd4;
      in8   = 16'h5555;
      @(posedge clk);
      #1;
      load8 = 1'b0;
      chk("rst_write_lost", 32'(out8), 32'h0);

      // release reset
      @(negedge clk);
      rst_n = 1'b1;

      // 2: single write
      wr8_at(3'd3, 16'hBEEF);
      addr8 = 3'd3;
      #1;
      chk("w3_out", 32'(out8), 32'hBEEF);
      chk("w3_wr", 32'(wr8), 32'h1);
      addr8 = 3'd2;
      #1;
      chk("a2_out", 32'(out8), 32'h0);
      chk("a2_wr", 32'(wr8), 32'h0);

      // 3: read-during-write shows old value
      @(negedge clk);
      load8 = 1'b1;
      addr8 = 3'd5;
      in8   = 16'h1234;
      #1;
      chk("rdw_old", 32'(out8), 32'h0);
      chk("rdw_old_wr", 32'(wr8), 32'h0);
      @(posedge clk);
      #1;
      load8 = 1'b0;
      chk("rdw_new", 32'(out8), 32'h1234);

      // 3b: fill all words, read back
      for (int i = 0; i < 8; i++) begin
         wr8_at(3'(i), 16'(i * 16'h1111));
      end
      for (int i = 0; i < 8; i++) begin
         addr8 = 3'(i);
         #1;
         chk($sformatf("fill_out%0d", i), 32'(out8), 32'(i * 16'h1111));
         chk($sformatf("fill_wr%0d", i), 32'(wr8), 32'h1);
      end

      // 4: clear beats load
      @(negedge clk);
      load8 = 1'b1;
      clear = 1'b1;
      addr8 = 3'd1;
      in8   = 16'hFFFF;
      @(posedge clk);
      #1;
      load8 = 1'b0;
      clear = 1'b0;
      for (int i = 0; i < 8; i++) begin
         addr8 = 3'(i);
         #1;
         chk($sformatf("clr_out%0d", i), 32'(out8), 32'h0);
         chk($sformatf("clr_wr%0d", i), 32'(wr8), 32'h0);
      end

      // 5: DEPTH=5, out-of-range write ignored
      for (int i = 0; i < 5; i++) begin
         wr5_at(3'(i), 16'(16'hA000 + i));
      end
      wr5_at(3'd6, 16'hAAAA);
      for (int i = 5; i < 8; i++) begin
         addr5 = 3'(i);
         #1;
         chk($sformatf("oor_out%0d", i), 32'(out5), 32'h0);
         chk($sformatf("oor_wr%0d", i), 32'(wr5), 32'h0);
      end
      for (int i = 0; i < 5; i++) begin
         addr5 = 3'(i);
         #1;
         chk($sformatf("d5_out%0d", i), 32'(out5), 32'(16'hA000 + i));
         chk($sformatf("d5_wr%0d", i), 32'(wr5), 32'h1);
      end

      // 6: async reset between edges
      wr8_at(3'd7, 16'h00FF);
      addr8 = 3'd7;
      #1;
      chk("a7_out", 32'(out8), 32'h00FF);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_out", 32'(out8), 32'h0);
      chk("async_wr", 32'(wr8), 32'h0);
      addr5 = 3'd2;
      #1;
      chk("async_d5", 32'(out5), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
